// File: rtl/reg_wb_sched.sv
// Writeback scheduler feeding the register file write port (we3/a3/wd3).
// Optional RAW scoreboard on pend_mask is enabled with `define WB_HAZARD_EN.
module reg_wb_sched #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_wd,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            we3,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd3,
  output logic [31:0]     pend_mask
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [4:0]      rd_mem_r [DEPTH];
  logic [XLEN-1:0] wd_mem_r [DEPTH];

  logic            push_s;
  logic            pop_s;
  logic            sel_valid_s;
  logic [4:0]      sel_rd_s;
  logic [XLEN-1:0] sel_wd_s;
  logic            sel_we_s;

  logic            we3_r;
  logic [4:0]      a3_r;
  logic [XLEN-1:0] wd3_r;

  // Readies depend on registered occupancy only, never on this cycle's pop.
  assign ld_ready  = (count_r != DEPTH_C);
  assign alu_ready = (count_r == {CW{1'b0}});

  // Write selection: queued loads first, then the ALU result.
  always_comb begin
    push_s      = ld_valid & ld_ready;
    pop_s       = (count_r != {CW{1'b0}});
    sel_valid_s = 1'b0;
    sel_rd_s    = 5'd0;
    sel_wd_s    = {XLEN{1'b0}};
    if (pop_s) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = rd_mem_r[rd_ptr_r];
      sel_wd_s    = wd_mem_r[rd_ptr_r];
    end else if (alu_valid) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = alu_rd;
      sel_wd_s    = alu_wd;
    end else begin
      sel_valid_s = 1'b0;
    end
    // x0 is consumed but never written.
    sel_we_s = sel_valid_s & (sel_rd_s != 5'd0);
  end

  // Load FIFO storage; stale entries are harmless once pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      rd_mem_r[wr_ptr_r] <= ld_rd;
      wd_mem_r[wr_ptr_r] <= ld_wd;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we3_r <= 1'b0;
      a3_r  <= 5'd0;
      wd3_r <= {XLEN{1'b0}};
    end else begin
      we3_r <= sel_we_s;
      if (sel_valid_s) begin
        a3_r  <= sel_rd_s;
        wd3_r <= sel_wd_s;
      end
    end
  end

  assign we3 = we3_r;
  assign a3  = a3_r;
  assign wd3 = wd3_r;

`ifdef WB_HAZARD_EN
  logic [31:0] pend_r;
  logic [31:0] set_s;
  logic [31:0] clr_s;
  logic [31:0] pend_nxt_s;

  // Scoreboard update; a new producer's set overrides a same-cycle clear.
  always_comb begin
    set_s = 32'h0;
    clr_s = 32'h0;
    if (iss_valid && (iss_rd != 5'd0)) begin
      set_s[iss_rd] = 1'b1;
    end else begin
      set_s = 32'h0;
    end
    if (sel_we_s) begin
      clr_s[sel_rd_s] = 1'b1;
    end else begin
      clr_s = 32'h0;
    end
    pend_nxt_s    = (pend_r & ~clr_s) | set_s;
    pend_nxt_s[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_r <= 32'h0;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  assign pend_mask = pend_r;
`else
  logic unused_iss_s;
  assign unused_iss_s = ^{iss_valid, iss_rd};
  assign pend_mask    = 32'h0;
`endif

endmodule

// File: tb/tb_reg_wb_sched.sv
// Self-checking bench for reg_wb_sched: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_reg_wb_sched;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
`ifdef WB_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0;
  logic            alu_ready;
  logic [4:0]      alu_rd = 5'd0;
  logic [XLEN-1:0] alu_wd = '0;
  logic            ld_valid = 1'b0;
  logic            ld_ready;
  logic [4:0]      ld_rd = 5'd0;
  logic [XLEN-1:0] ld_wd = '0;
  logic            iss_valid = 1'b0;
  logic [4:0]      iss_rd = 5'd0;
  logic            we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;
  logic [31:0]     pend_mask;

  reg_wb_sched #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_wd(ld_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .we3(we3), .a3(a3), .wd3(wd3), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit known  = 1'b0;

  typedef struct { logic [4:0] rd; logic [31:0] wd; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pend = 32'h0;

  typedef struct {
    bit av; logic [4:0] ar; logic [31:0] aw;
    bit lv; logic [4:0] lr; logic [31:0] lw;
    bit we1; logic [4:0] a1; logic [31:0] w1;
    bit we2; logic [4:0] a2; logic [31:0] w2;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: check readies, advance the model, then check the registered outputs.
  task automatic cycle();
    ent_t e;
    bit   iss;
    bit   exp_we;
    int   sz0;
    #1;
    if (known && rst_n) begin
      chk("alu_ready", {31'd0, alu_ready}, {31'd0, (q.size() == 0)});
      chk("ld_ready", {31'd0, ld_ready}, {31'd0, (q.size() != DEPTH)});
    end
    exp_we = 1'b0;
    e.rd = 5'd0;
    e.wd = 32'h0;
    if (!rst_n) begin
      q.delete();
      m_pend = 32'h0;
    end else begin
      sz0 = q.size();
      iss = 1'b0;
      if (sz0 > 0) begin
        e = q.pop_front();
        iss = 1'b1;
      end else if (alu_valid) begin
        e.rd = alu_rd;
        e.wd = alu_wd;
        iss = 1'b1;
      end
      if (ld_valid && sz0 != DEPTH) q.push_back('{rd: ld_rd, wd: ld_wd});
      exp_we = iss && (e.rd != 5'd0);
      if (HZ) begin
        if (exp_we) m_pend[e.rd] = 1'b0;
        if (iss_valid && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("we3", {31'd0, we3}, {31'd0, exp_we});
    if (!rst_n) begin
      chk("a3_rst", {27'd0, a3}, 32'd0);
      chk("wd3_rst", wd3, 32'd0);
    end else if (exp_we) begin
      chk("a3", {27'd0, a3}, {27'd0, e.rd});
      chk("wd3", wd3, e.wd);
    end
    chk("pend_mask", pend_mask, m_pend);
    known = 1'b1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    iss_valid = 1'b0;
  endtask

  initial begin
    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0};
    vt[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0};
    vt[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hCAFE0001, 1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hCAFE0001};
    vt[3] = '{1'b1, 5'd9,  32'h0000AAAA, 1'b1, 5'd10, 32'h00005555, 1'b1, 5'd9,  32'h0000AAAA, 1'b1, 5'd10, 32'h00005555};
    vt[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h00000077, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0};
    vt[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0};
    vt[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0};

    // Reset held two cycles with a load offered.
    rst_n = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_wd = 32'h11;
    repeat (2) cycle();
    rst_n = 1'b1;
    idle_inputs();
    #1;
    chk("rst_we3", {31'd0, we3}, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    cycle();

    // Vector table, each row applied from an empty FIFO then one idle cycle.
    for (int i = 0; i < 7; i++) begin
      alu_valid = vt[i].av; alu_rd = vt[i].ar; alu_wd = vt[i].aw;
      ld_valid  = vt[i].lv; ld_rd  = vt[i].lr; ld_wd  = vt[i].lw;
      cycle();
      chk($sformatf("vec%0d_we1", i), {31'd0, we3}, {31'd0, vt[i].we1});
      if (vt[i].we1) chk($sformatf("vec%0d_a1", i), {27'd0, a3}, {27'd0, vt[i].a1});
      if (vt[i].we1) chk($sformatf("vec%0d_w1", i), wd3, vt[i].w1);
      idle_inputs();
      cycle();
      chk($sformatf("vec%0d_we2", i), {31'd0, we3}, {31'd0, vt[i].we2});
      if (vt[i].we2) chk($sformatf("vec%0d_a2", i), {27'd0, a3}, {27'd0, vt[i].a2});
      if (vt[i].we2) chk($sformatf("vec%0d_w2", i), wd3, vt[i].w2);
    end

    // Priority: loads x7, x8 back-to-back; ALU x9 waits for the FIFO to drain.
    ld_valid = 1'b1; ld_rd = 5'd7; ld_wd = 32'd1;
    cycle();
    ld_rd = 5'd8; ld_wd = 32'd2;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = 32'd3;
    #1; chk("prio_alu_ready_low", {31'd0, alu_ready}, 32'd0);
    cycle();
    chk("prio_w7", {27'd0, a3}, 32'd7);
    ld_valid = 1'b0;
    cycle();
    chk("prio_w8", {27'd0, a3}, 32'd8);
    cycle();
    chk("prio_w9", {27'd0, a3}, 32'd9);
    chk("prio_d9", wd3, 32'd3);
    idle_inputs();
    cycle();

    // Continuous loads with the ALU idle: all written once, in order.
    ld_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ld_rd = 5'(20 + i); ld_wd = 32'h100 + 32'(i);
      cycle();
    end
    idle_inputs();
    repeat (2) cycle();

    // Scoreboard set, same-cycle set/clear, then clear.
    iss_valid = 1'b1; iss_rd = 5'd3;
    cycle();
    chk("sb_set", pend_mask, HZ ? 32'h8 : 32'h0);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h33;
    cycle();
    chk("sb_setwins", pend_mask, HZ ? 32'h8 : 32'h0);
    iss_valid = 1'b0;
    cycle();
    chk("sb_clear", pend_mask, 32'h0);
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 5'd0;
    cycle();
    chk("sb_x0", pend_mask, 32'h0);
    idle_inputs();

    // Reset with loads in flight discards the queue.
    iss_valid = 1'b1; iss_rd = 5'd6;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_wd = 32'h44;
    cycle();
    iss_valid = 1'b0;
    ld_rd = 5'd6; ld_wd = 32'h66;
    cycle();
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("midq_no_we", {31'd0, we3}, 32'd0);
      chk("midq_pend", pend_mask, 32'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      alu_valid = ($urandom_range(0, 1) == 1);
      alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_wd    = $urandom;
      ld_valid  = ($urandom_range(0, 2) != 0);
      ld_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ld_wd     = $urandom;
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = 5'($urandom_range(0, 31));
      rst_n     = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst_n = 1'b1;
    idle_inputs();
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
